ils_trace_checker: RTL and testbench
====================================

# ils_trace_checker

Lock-step commit checker for the sodor5 verification harness: the consuming end of the ILS (I-type ALU / load / store) stimulus stream. Receives architectural commit events (register writebacks and stores) from the pipelined core and from the reference model. Buffers each side in an in-order FIFO and compares the streams entry by entry. Raises a sticky, coded error on the first divergence, so random-instruction runs self-check instead of relying on waveform inspection.

## Interface

Parameters:
- DEPTH, 8: entries per side FIFO; must be a power of two, ≥2.
- WORD_SIZE, 32: data/address width.
- TIMEOUT, 64: cycles one side may hold unmatched entries before an error; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- dut_valid  in  1  core commit event this cycle.
- dut_is_store  in  1  1 = store, 0 = register writeback.
- dut_addr  in  WORD_SIZE  writeback: rd index, zero-extended; store: byte address.
- dut_data  in  WORD_SIZE  writeback value or store data.
- dut_mask  in  4  store byte-enable; ignored for writebacks.
- ref_valid, ref_is_store, ref_addr, ref_data, ref_mask  in  1/1/WORD_SIZE/WORD_SIZE/4  same fields, reference model side.
- match_count  out  16  compared-equal pairs, saturating.
- error  out  1  sticky error flag.
- err_code  out  2  0 none, 1 mismatch, 2 timeout, 3 overflow.
- err_index  out  16  match_count value when the error latched.
- pending  out  1  either FIFO non-empty.

## Operation

- Filter:
  - A writeback with addr == 0 is dropped and never pushed.
  - Stores with mask == 0 are dropped.
  - Filtering is identical on both sides.
- Push: a valid, unfiltered event is written at the tail of its side's FIFO.
- Compare: when both heads are valid and the state is CHECK, both heads are popped together in the same cycle. The pair matches iff all of the following hold:
  - is_store is equal on both sides;
  - addr is equal on both sides;
  - for writebacks, data is equal;
  - for stores, mask is equal and data is equal on every byte lane whose mask bit is set.
- On a match, match_count is incremented, saturating at 0xFFFF.
- On a mismatch: error=1, err_code=1, err_index=match_count, and the state moves to ERROR.
- Timeout:
  - A counter increments on every cycle in which exactly one FIFO is non-empty and no pop occurs.
  - It clears on any pop, and whenever both FIFOs are empty.
  - When it reaches TIMEOUT: err_code=2 and the state moves to ERROR.
- Overflow:
  - Pushing into a full FIFO, with no pop on that side in the same cycle, sets err_code=3 and moves the state to ERROR.
  - The event is discarded.
  - Push into a full FIFO while that side pops in the same cycle is legal and is not an overflow.
- FSM:
  - CHECK → ERROR on the first error condition.
  - ERROR is absorbing until reset_n is asserted.
  - In ERROR: no pops, pushes are ignored, and the error outputs hold.
- Error priority, when several conditions occur in the same cycle: overflow > mismatch > timeout. Exactly one code is latched.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Timing

- Reset values (asynchronous, applied immediately on reset_n low):
  - match_count=0, error=0, err_code=0, err_index=0, pending=0.
  - Both FIFOs empty, timeout counter=0, state=CHECK.
- Reset asserted mid-run discards all buffered entries. No error is reported for them.
- Push latency: an entry pushed at edge N is visible at the head from edge N onward. The earliest pop is edge N+1.
- Both sides pushing at edge N into empty FIFOs:
  - pop and compare at edge N+1;
  - match_count/error update visible after edge N+1.
- Fixed compare latency: 1 cycle from both heads valid to a registered result.
- pending is registered and reflects FIFO occupancy after each edge.
- Timeout latches at the edge where the counter reaches TIMEOUT: exactly TIMEOUT cycles after the one-sided condition began, with no intervening pop.
- Steady state: sustains one compare per cycle with both sides pushing every cycle, with no occupancy growth.

## Test plan

- Identical streams: 20 random matched events per side, same cycles → match_count=20, error=0, pending=0 two cycles after the last push.
- Skewed arrival: ref lags dut by 5 cycles on 6 equal events (DEPTH=8) → no overflow, match_count=6, err_code=0.
- Masked store:
  - dut store data 0xAABBCCDD vs ref 0x11BBCCDD with mask=4'b0111 → match.
  - The same pair with mask=4'b1111 → err_code=1, err_index=0.
- x0 filter: dut writeback to rd=0 plus a matched writeback rd=5 data=0x1234 on both sides → match_count=1, no timeout.
- Timeout: one dut event, none from ref, TIMEOUT=64 → error=1, err_code=2 exactly 64 cycles after the push.
- Overflow and reset:
  - 9 dut pushes with no ref events (DEPTH=8) → err_code=3 on the 9th push.
  - Then reset_n low for 1 cycle → all outputs 0, and a subsequent matched pair gives match_count=1.

Source files
------------

// File: rtl/ils_trace_checker.sv
// ils_trace_checker
//
// Lock-step commit checker. This block takes architectural commit events
// (register writebacks and stores) from the core ("dut") and from the
// reference model ("ref"). Each side goes into its own in-order FIFO. The
// two FIFO heads are compared pair by pair. The first divergence latches a
// sticky, coded error.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   dut_* / ref_*           commit event inputs: valid, is_store, addr, data, mask
//   match_count   out 16    number of pairs that compared equal (saturating)
//   error         out 1     sticky error flag
//   err_code      out 2     0 none, 1 mismatch, 2 timeout, 3 overflow
//   err_index     out 16    match_count value at the moment the error latched
//   pending       out 1     either FIFO holds entries (registered)
//
// Store data lanes assume WORD_SIZE >= 32 (four byte lanes, one per mask bit).

module ils_trace_checker #(
  parameter int DEPTH     = 8,
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dut_valid,
  input  logic                 dut_is_store,
  input  logic [WORD_SIZE-1:0] dut_addr,
  input  logic [WORD_SIZE-1:0] dut_data,
  input  logic [3:0]           dut_mask,
  input  logic                 ref_valid,
  input  logic                 ref_is_store,
  input  logic [WORD_SIZE-1:0] ref_addr,
  input  logic [WORD_SIZE-1:0] ref_data,
  input  logic [3:0]           ref_mask,
  output logic [15:0]          match_count,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [15:0]          err_index,
  output logic                 pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + 2 * WORD_SIZE;     // {is_store, mask, addr, data}
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_CHECK = 1'b0, ST_ERROR = 1'b1} state_t;

  state_t r_state, w_state_next;

  logic [15:0]   r_match_count;
  logic          r_error;
  logic [1:0]    r_err_code, w_err_code_next;
  logic [15:0]   r_err_index;
  logic          r_pending;
  logic [TW-1:0] r_to_cnt;

  // Side 0 = dut, side 1 = ref
  logic [1:0]    w_in_valid;
  logic [EW-1:0] w_in_entry [2];
  logic [1:0]    w_empty, w_full, w_push, w_next_empty;
  logic [EW-1:0] w_head [2];

  logic                 w_h_is   [2];
  logic [3:0]           w_h_mask [2];
  logic [WORD_SIZE-1:0] w_h_addr [2];
  logic [WORD_SIZE-1:0] w_h_data [2];

  logic       w_pop, w_match, w_one_sided, w_timeout, w_ovf, w_mis;
  logic [3:0] w_lane_ok;

  // Writebacks to x0 and stores with no enabled bytes carry no architectural
  // effect. Both are filtered before the FIFO, the same way on each side.
  assign w_in_valid[0] = dut_valid & (dut_is_store ? (dut_mask != 4'd0) : (dut_addr != '0));
  assign w_in_valid[1] = ref_valid & (ref_is_store ? (ref_mask != 4'd0) : (ref_addr != '0));
  assign w_in_entry[0] = {dut_is_store, dut_mask, dut_addr, dut_data};
  assign w_in_entry[1] = {ref_is_store, ref_mask, ref_addr, ref_data};

  // Pairs pop together only while checking and when both heads are valid.
  assign w_pop = (r_state == ST_CHECK) && !w_empty[0] && !w_empty[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      logic [EW-1:0] r_mem [DEPTH];
      logic [AW:0]   r_wr_ptr, r_rd_ptr;
      logic [AW:0]   w_wr_next, w_rd_next;

      assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
      assign w_full[gi]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      assign w_head[gi]  = r_mem[r_rd_ptr[AW-1:0]];

      // A full FIFO still accepts a push when its head pops in the same cycle.
      assign w_push[gi] = (r_state == ST_CHECK) && w_in_valid[gi] && (!w_full[gi] || w_pop);

      assign w_wr_next = r_wr_ptr + (AW+1)'(w_push[gi]);
      assign w_rd_next = r_rd_ptr + (AW+1)'(w_pop);
      assign w_next_empty[gi] = (w_wr_next == w_rd_next);

      assign w_h_is[gi]   = w_head[gi][EW-1];
      assign w_h_mask[gi] = w_head[gi][EW-2 -: 4];
      assign w_h_addr[gi] = w_head[gi][2*WORD_SIZE-1 -: WORD_SIZE];
      assign w_h_data[gi] = w_head[gi][WORD_SIZE-1:0];

      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wr_ptr[AW-1:0]] <= w_in_entry[gi];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          r_wr_ptr <= w_wr_next;
          r_rd_ptr <= w_rd_next;
        end
      end
    end

    // Store data only matters on byte lanes that the store actually writes.
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_ok[gi] = !w_h_mask[0][gi] ||
                             (w_h_data[0][8*gi +: 8] == w_h_data[1][8*gi +: 8]);
    end
  endgenerate

  always_comb begin
    w_match = 1'b0;
    if ((w_h_is[0] == w_h_is[1]) && (w_h_addr[0] == w_h_addr[1])) begin
      if (w_h_is[0]) w_match = (w_h_mask[0] == w_h_mask[1]) && (&w_lane_ok);
      else           w_match = (w_h_data[0] == w_h_data[1]);
    end
  end

  assign w_mis       = w_pop && !w_match;
  assign w_ovf       = (r_state == ST_CHECK) && |(w_in_valid & w_full & ~{2{w_pop}});
  assign w_one_sided = w_empty[0] ^ w_empty[1];
  // The counter reaching TIMEOUT on this edge is the timeout event itself.
  assign w_timeout   = (r_state == ST_CHECK) && w_one_sided && (r_to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = 2'd0;
    if (r_state == ST_CHECK) begin
      if (w_ovf)          w_err_code_next = 2'd3;
      else if (w_mis)     w_err_code_next = 2'd1;
      else if (w_timeout) w_err_code_next = 2'd2;
      if (w_err_code_next != 2'd0) w_state_next = ST_ERROR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_CHECK;
      r_match_count <= '0;
      r_error       <= 1'b0;
      r_err_code    <= 2'd0;
      r_err_index   <= '0;
      r_pending     <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= !(w_next_empty[0] && w_next_empty[1]);

      if (w_pop && w_match && (r_match_count != 16'hFFFF))
        r_match_count <= r_match_count + 16'd1;

      if (r_state == ST_CHECK && w_err_code_next != 2'd0) begin
        r_error     <= 1'b1;
        r_err_code  <= w_err_code_next;
        r_err_index <= r_match_count;
      end

      if (w_pop || (w_empty[0] && w_empty[1])) r_to_cnt <= '0;
      else if (r_state == ST_CHECK && w_one_sided) r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign match_count = r_match_count;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign err_index   = r_err_index;
  assign pending     = r_pending;

endmodule

// File: tb/tb_ils_trace_checker.sv
// tb_ils_trace_checker
//
// Directed bench for ils_trace_checker (DEPTH=8, WORD_SIZE=32, TIMEOUT=64).
// A table of single commit pairs is applied one pair per reset. Then
// hand-written sequences cover streaming, skew, the x0 filter, timeout,
// overflow and mid-run reset.

module tb_ils_trace_checker;

  logic        clk;
  logic        reset_n;
  logic        dut_valid, dut_is_store;
  logic [31:0] dut_addr, dut_data;
  logic [3:0]  dut_mask;
  logic        ref_valid, ref_is_store;
  logic [31:0] ref_addr, ref_data;
  logic [3:0]  ref_mask;
  logic [15:0] match_count;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] err_index;
  logic        pending;

  int n_checks = 0;
  int n_errors = 0;

  ils_trace_checker #(.DEPTH(8), .WORD_SIZE(32), .TIMEOUT(64)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dut_valid    (dut_valid),
    .dut_is_store (dut_is_store),
    .dut_addr     (dut_addr),
    .dut_data     (dut_data),
    .dut_mask     (dut_mask),
    .ref_valid    (ref_valid),
    .ref_is_store (ref_is_store),
    .ref_addr     (ref_addr),
    .ref_data     (ref_data),
    .ref_mask     (ref_mask),
    .match_count  (match_count),
    .error        (error),
    .err_code     (err_code),
    .err_index    (err_index),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        d_is;
    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic [3:0]  d_mask;
    logic        r_is;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_mask;
    logic        exp_match;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge. Outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dut_valid = 1'b0; dut_is_store = 1'b0; dut_addr = '0; dut_data = '0; dut_mask = '0;
    ref_valid = 1'b0; ref_is_store = 1'b0; ref_addr = '0; ref_data = '0; ref_mask = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic drive_dut(input logic is_st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    dut_valid = 1'b1; dut_is_store = is_st; dut_addr = a; dut_data = d; dut_mask = m;
  endtask

  task automatic drive_ref(input logic is_st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    ref_valid = 1'b1; ref_is_store = is_st; ref_addr = a; ref_data = d; ref_mask = m;
  endtask

  logic        s_is   [20];
  logic [31:0] s_addr [20];
  logic [31:0] s_data [20];
  logic [3:0]  s_mask [20];

  initial begin
    //            d_is  d_addr     d_data        d_mask   r_is  r_addr     r_data        r_mask   match
    vecs[0] = '{1'b0, 32'd5,     32'h0000_1234, 4'h0,  1'b0, 32'd5,     32'h0000_1234, 4'h0,  1'b1};
    vecs[1] = '{1'b0, 32'd5,     32'h0000_1234, 4'h0,  1'b0, 32'd5,     32'h0000_1235, 4'h0,  1'b0};
    vecs[2] = '{1'b0, 32'd5,     32'h0000_1234, 4'h0,  1'b0, 32'd6,     32'h0000_1234, 4'h0,  1'b0};
    vecs[3] = '{1'b1, 32'h100,   32'h0000_1234, 4'hF,  1'b0, 32'h100,   32'h0000_1234, 4'hF,  1'b0};
    vecs[4] = '{1'b1, 32'h200,   32'hAABB_CCDD, 4'h7,  1'b1, 32'h200,   32'h11BB_CCDD, 4'h7,  1'b1};
    vecs[5] = '{1'b1, 32'h200,   32'hAABB_CCDD, 4'hF,  1'b1, 32'h200,   32'h11BB_CCDD, 4'hF,  1'b0};
    vecs[6] = '{1'b1, 32'h300,   32'h5555_5555, 4'h1,  1'b1, 32'h300,   32'h5555_5555, 4'h2,  1'b0};
    vecs[7] = '{1'b0, 32'd9,     32'hDEAD_BEEF, 4'h3,  1'b0, 32'd9,     32'hDEAD_BEEF, 4'hC,  1'b1};
    vecs[8] = '{1'b1, 32'h400,   32'h0000_00FF, 4'h1,  1'b1, 32'h404,   32'h0000_00FF, 4'h1,  1'b0};

    idle_inputs();
    reset_n = 1'b0;
    #2;
    check("reset match_count", 32'(match_count), 32'd0);
    check("reset error",       32'(error),       32'd0);
    check("reset err_code",    32'(err_code),    32'd0);
    check("reset err_index",   32'(err_index),   32'd0);
    check("reset pending",     32'(pending),     32'd0);
    do_reset();

    // ---- Table: one pair per reset, pushed together, compared one edge later
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive_dut(vecs[i].d_is, vecs[i].d_addr, vecs[i].d_data, vecs[i].d_mask);
      drive_ref(vecs[i].r_is, vecs[i].r_addr, vecs[i].r_data, vecs[i].r_mask);
      step();
      check($sformatf("vec%0d pending after push", i), 32'(pending), 32'd1);
      idle_inputs();
      step();
      check($sformatf("vec%0d match_count", i), 32'(match_count), vecs[i].exp_match ? 32'd1 : 32'd0);
      check($sformatf("vec%0d error", i),       32'(error),       vecs[i].exp_match ? 32'd0 : 32'd1);
      check($sformatf("vec%0d err_code", i),    32'(err_code),    vecs[i].exp_match ? 32'd0 : 32'd1);
      check($sformatf("vec%0d err_index", i),   32'(err_index),   32'd0);
      check($sformatf("vec%0d pending", i),     32'(pending),     32'd0);
      $display("vec%0d: dut{st=%0b a=%0h d=%0h m=%0h} ref{st=%0b a=%0h d=%0h m=%0h} match_count=%0d err_code=%0d",
               i, vecs[i].d_is, vecs[i].d_addr, vecs[i].d_data, vecs[i].d_mask,
               vecs[i].r_is, vecs[i].r_addr, vecs[i].r_data, vecs[i].r_mask, match_count, err_code);
    end

    // ---- Identical streams: 20 matched events, same cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_is[i]   = 1'($urandom_range(0, 1));
      s_addr[i] = s_is[i] ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom_range(1, 31));
      s_data[i] = $urandom;
      s_mask[i] = 4'($urandom_range(1, 15));
    end
    for (int i = 0; i < 20; i++) begin
      drive_dut(s_is[i], s_addr[i], s_data[i], s_mask[i]);
      drive_ref(s_is[i], s_addr[i], s_data[i], s_mask[i]);
      step();
    end
    idle_inputs();
    step();
    step();
    check("stream match_count", 32'(match_count), 32'd20);
    check("stream error",       32'(error),       32'd0);
    check("stream pending",     32'(pending),     32'd0);
    $display("stream: 20 pairs, match_count=%0d err_code=%0d", match_count, err_code);

    // ---- Skewed arrival: ref lags dut by 5 cycles
    do_reset();
    for (int t = 0; t < 11; t++) begin
      idle_inputs();
      if (t < 6)  drive_dut(1'b0, 32'(t + 1), 32'(100 + t), 4'h0);
      if (t >= 5) drive_ref(1'b0, 32'(t - 4), 32'(95 + t), 4'h0);
      step();
    end
    idle_inputs();
    step();
    step();
    check("skew match_count", 32'(match_count), 32'd6);
    check("skew err_code",    32'(err_code),    32'd0);
    check("skew pending",     32'(pending),     32'd0);
    $display("skew: 6 pairs, match_count=%0d err_code=%0d", match_count, err_code);

    // ---- x0 filter: a dut writeback to x0 must never be queued
    do_reset();
    drive_dut(1'b0, 32'd0, 32'h99, 4'h0);
    step();
    check("x0 pending", 32'(pending), 32'd0);
    drive_dut(1'b0, 32'd5, 32'h1234, 4'h0);
    drive_ref(1'b0, 32'd5, 32'h1234, 4'h0);
    step();
    idle_inputs();
    for (int k = 0; k < 70; k++) step();
    check("x0 match_count", 32'(match_count), 32'd1);
    check("x0 error",       32'(error),       32'd0);
    $display("x0: match_count=%0d err_code=%0d", match_count, err_code);

    // ---- Timeout: one dut event, no ref, exactly 64 cycles after the push
    do_reset();
    drive_dut(1'b0, 32'd3, 32'h77, 4'h0);
    step();
    idle_inputs();
    for (int k = 0; k < 63; k++) step();
    check("timeout not early", 32'(error), 32'd0);
    step();
    check("timeout error",     32'(error),     32'd1);
    check("timeout err_code",  32'(err_code),  32'd2);
    check("timeout err_index", 32'(err_index), 32'd0);
    $display("timeout: error=%0b err_code=%0d", error, err_code);

    // ---- Overflow, then a sticky check, then a mid-run reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_dut(1'b0, 32'(i + 1), 32'(i), 4'h0);
      step();
    end
    check("ovf 8 pushes error", 32'(error),   32'd0);
    check("ovf 8 pushes pend",  32'(pending), 32'd1);
    drive_dut(1'b0, 32'd9, 32'd8, 4'h0);
    step();
    check("ovf error",    32'(error),    32'd1);
    check("ovf err_code", 32'(err_code), 32'd3);
    drive_ref(1'b0, 32'd1, 32'd0, 4'h0);
    drive_dut(1'b0, 32'd1, 32'd0, 4'h0);
    step();
    idle_inputs();
    step();
    check("ovf sticky err_code", 32'(err_code),    32'd3);
    check("ovf no compare",      32'(match_count), 32'd0);
    $display("overflow: err_code=%0d match_count=%0d", err_code, match_count);

    reset_n = 1'b0;
    #2;
    check("mid reset error",    32'(error),       32'd0);
    check("mid reset err_code", 32'(err_code),    32'd0);
    check("mid reset pending",  32'(pending),     32'd0);
    check("mid reset match",    32'(match_count), 32'd0);
    step();
    reset_n = 1'b1;
    drive_dut(1'b1, 32'h80, 32'hCAFE_F00D, 4'h3);
    drive_ref(1'b1, 32'h80, 32'h1234_F00D, 4'h3);
    step();
    idle_inputs();
    step();
    check("post reset match_count", 32'(match_count), 32'd1);
    check("post reset error",       32'(error),       32'd0);
    check("post reset pending",     32'(pending),     32'd0);
    $display("post-reset pair: match_count=%0d err_code=%0d", match_count, err_code);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
